// File: rtl/sync_inverse_arith_unit.sv
// Inverse companion of the synchronous arithmetic unit: left shift, shift-add multiply,
// U2-to-ZM conversion. Define SYNC_INV_MUL_EARLY_TERM_EN to let MUL finish early.
module sync_inverse_arith_unit #(
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [M-1:0] iarg_A,
  input  logic [M-1:0] iarg_B,
  input  logic [3:0]   iop,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned CntW = $clog2(M);
  localparam logic [CntW-1:0] LastCnt = CntW'(M - 1);
  localparam logic [M-1:0] MVal = M'(M);

  localparam logic [3:0] OpShl  = 4'b0000;
  localparam logic [3:0] OpMul  = 4'b0001;
  localparam logic [3:0] OpU2Zm = 4'b0010;

  typedef enum logic {StIdle, StMul} state_t;

  state_t          r_state;
  logic [2*M-1:0]  r_acc;
  logic [2*M-1:0]  r_mcand;
  logic [M-1:0]    r_mplier;
  logic [CntW-1:0] r_cnt;

  // Status layout: {ERROR, odd parity, ZEROS, OVERFLOW}, always taken from the new result.
  function automatic logic [3:0] f_status(input logic [M-1:0] res, input logic ovf);
    return {1'b0, ^res, (res == '0), ovf};
  endfunction

  logic [2*M-1:0] w_shl_wide;
  logic [M-2:0]   w_neg_low;
  logic           w_min_neg;
  logic [M-1:0]   w_sc_res;
  logic           w_sc_ovf;
  logic           w_sc_err;

  // Widening the shift keeps the shifted-out bits for overflow detection.
  assign w_shl_wide = {{M{1'b0}}, iarg_A} << iarg_B;
  assign w_neg_low  = ~iarg_A[M-2:0] + 1'b1;
  assign w_min_neg  = (iarg_A == {1'b1, {(M-1){1'b0}}});

  always_comb begin
    w_sc_res = '0;
    w_sc_ovf = 1'b0;
    w_sc_err = 1'b0;
    case (iop)
      OpShl: begin
        if (iarg_B >= MVal) begin
          w_sc_err = 1'b1;
        end else begin
          w_sc_res = w_shl_wide[M-1:0];
          w_sc_ovf = |w_shl_wide[2*M-1:M];
        end
      end
      OpU2Zm: begin
        if (!iarg_A[M-1]) begin
          w_sc_res = iarg_A;
        end else if (w_min_neg) begin
          w_sc_res = '1;
          w_sc_ovf = 1'b1;
        end else begin
          w_sc_res = {1'b1, w_neg_low};
        end
      end
      default: w_sc_err = 1'b1;
    endcase
  end

  logic [2*M-1:0] w_acc_next;
  logic           w_last;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef SYNC_INV_MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this iteration's shift.
  assign w_last = (r_cnt == LastCnt) || (r_mplier[M-1:1] == '0);
`else
  assign w_last = (r_cnt == LastCnt);
`endif

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      o_result <= '0;
      o_status <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (iop == OpMul) begin
              r_state  <= StMul;
              o_busy   <= 1'b1;
              r_acc    <= '0;
              r_mcand  <= {{M{1'b0}}, iarg_A};
              r_mplier <= iarg_B;
              r_cnt    <= '0;
            end else begin
              o_done <= 1'b1;
              if (w_sc_err) begin
                o_status <= 4'b1000;
              end else begin
                o_result <= w_sc_res;
                o_status <= f_status(w_sc_res, w_sc_ovf);
              end
            end
          end
        end
        StMul: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state  <= StIdle;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_result <= w_acc_next[M-1:0];
            o_status <= f_status(w_acc_next[M-1:0], |w_acc_next[2*M-1:M]);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_inverse_arith_unit.sv
// Self-checking bench for sync_inverse_arith_unit at M=8: directed cases plus random
// commands checked against an arithmetic reference model.
module tb_sync_inverse_arith_unit;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_start = 1'b0;
  logic [M-1:0] iarg_A = '0;
  logic [M-1:0] iarg_B = '0;
  logic [3:0]   iop = '0;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;
  logic         o_busy;
  logic         o_done;

  int total = 0;
  int bad = 0;
  logic [7:0] m_res = '0;

  sync_inverse_arith_unit #(.M(M)) dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .iarg_A   (iarg_A),
    .iarg_B   (iarg_B),
    .iop      (iop),
    .o_result (o_result),
    .o_status (o_status),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, prior result kept for ERROR.
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [3:0] s);
    int p;
    bit ovf;
    bit err;
    err = 0;
    ovf = 0;
    r = m_res;
    case (op)
      4'd0: begin
        if (b >= 8) err = 1;
        else begin
          p = int'(a) * (1 << b);
          r = p[7:0];
          ovf = (p >= 256);
        end
      end
      4'd1: begin
        p = int'(a) * int'(b);
        r = p[7:0];
        ovf = (p >= 256);
      end
      4'd2: begin
        if (a == 8'h80) begin
          r = 8'hFF;
          ovf = 1;
        end else if (a >= 8'h80) begin
          p = 256 - int'(a);
          r = 8'h80 | p[7:0];
        end else begin
          r = a;
        end
      end
      default: err = 1;
    endcase
    if (err) s = 4'b1000;
    else s = {1'b0, ($countones(r) % 2) == 1, r == 8'h00, ovf};
  endtask

  function automatic int mul_lat(input logic [7:0] b);
`ifdef SYNC_INV_MUL_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 1; i < 8; i++) if (b[i]) n = i + 1;
    return n;
`else
    return M;
`endif
  endfunction

  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit poke);
    logic [7:0] er;
    logic [3:0] es;
    int lat;
    model(op, a, b, er, es);
    @(negedge clk);
    i_start = 1'b1;
    iop = op;
    iarg_A = a;
    iarg_B = b;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    iop = 4'($urandom);
    iarg_A = 8'($urandom);
    iarg_B = 8'($urandom);
    if (op != 4'd1) begin
      chk("sc_done", 32'(o_done), 1);
      chk("sc_busy", 32'(o_busy), 0);
      chk("sc_result", 32'(o_result), 32'(er));
      chk("sc_status", 32'(o_status), 32'(es));
    end else begin
      lat = mul_lat(b);
      chk("mul_busy_e0", 32'(o_busy), 1);
      chk("mul_done_e0", 32'(o_done), 0);
      for (int k = 1; k <= lat; k++) begin
        if (poke && k == 2) begin
          i_start = 1'b1;
          iop = 4'd0;
        end
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        if (k < lat) begin
          chk("mul_busy_mid", 32'(o_busy), 1);
          chk("mul_done_mid", 32'(o_done), 0);
        end else begin
          chk("mul_done", 32'(o_done), 1);
          chk("mul_busy_end", 32'(o_busy), 0);
          chk("mul_result", 32'(o_result), 32'(er));
          chk("mul_status", 32'(o_status), 32'(es));
        end
      end
    end
    m_res = er;
    @(negedge clk);
    chk("done_drop", 32'(o_done), 0);
    chk("hold_result", 32'(o_result), 32'(er));
    chk("hold_status", 32'(o_status), 32'(es));
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;

    repeat (2) @(negedge clk);
    chk("rst_result", 32'(o_result), 0);
    chk("rst_status", 32'(o_status), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    i_reset = 1'b1;

    run_cmd(4'd1, 8'd15, 8'd17, 1'b0);
    run_cmd(4'd1, 8'd16, 8'd16, 1'b1);
    run_cmd(4'd0, 8'h81, 8'd1, 1'b0);
    run_cmd(4'd0, 8'h81, 8'd8, 1'b0);
    run_cmd(4'd0, 8'h5A, 8'd0, 1'b0);
    run_cmd(4'd2, 8'hFB, 8'd0, 1'b0);
    run_cmd(4'd2, 8'h80, 8'd0, 1'b0);
    run_cmd(4'd2, 8'h37, 8'd0, 1'b0);
    run_cmd(4'd7, 8'h12, 8'h34, 1'b0);
    run_cmd(4'd1, 8'd9, 8'd0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 4))
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'($urandom_range(3, 15));
        default: begin
          op = 4'd0;
          b = 8'($urandom_range(0, 9));
        end
      endcase
      run_cmd(op, a, b, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a multiply must clear everything at once.
    run_cmd(4'd2, 8'h37, 8'd0, 1'b0);
    @(negedge clk);
    i_start = 1'b1;
    iop = 4'd1;
    iarg_A = 8'd200;
    iarg_B = 8'd3;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    #1;
    chk("midrst_result", 32'(o_result), 0);
    chk("midrst_status", 32'(o_status), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_done", 32'(o_done), 0);
    @(negedge clk);
    i_reset = 1'b1;
    m_res = '0;
    run_cmd(4'd1, 8'd3, 8'd5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_inverse_arith_unit.md
Name: sync_inverse_arith_unit

Overview:
Companion to the existing synchronous arithmetic unit. It performs the inverse operations:
- left shift (inverse of the logical right shift)
- sequential shift-add multiply (inverse of divide)
- U2-to-ZM conversion (inverse of ZM-to-U2)

Commands are accepted through a start/busy/done handshake. Multiply is multi-cycle via an internal FSM. Status layout is identical to the existing unit so downstream status decoding is shared.

Parameters:
M, 32, operand/result width in bits (M >= 4)

Ports:
clk  input  1  clock, rising edge
i_reset  input  1  reset, asynchronous, active-low
i_start  input  1  command valid; accepted only when o_busy=0
iarg_A  input  M  operand A
iarg_B  input  M  operand B
iop  input  4  opcode
o_result  output  M  registered result
o_status  output  4  [3]=ERROR, [2]=NOT_EVEN_1 (odd parity), [1]=ZEROS, [0]=OVERFLOW
o_busy  output  1  high while a multiply is in progress
o_done  output  1  one-cycle pulse: o_result/o_status valid and updated

Behaviour:
- Reset (i_reset=0, any time, including mid-multiply): o_result=0, o_status=0, o_busy=0, o_done=0, FSM=IDLE, internal accumulator/counter cleared. Takes effect immediately; no partial result survives.
- Accept edge E0: a rising edge with i_start=1 and o_busy=0. i_start while o_busy=1 is ignored; no queueing.
- Operands and iop are captured at E0. Input changes after E0 have no effect.
- Opcodes:
  - 4'b0000 SHL: o_result = A << B.
  - 4'b0001 MUL: unsigned A*B; o_result = low M bits.
  - 4'b0010 U2_TO_ZM: convert A from U2 to sign-magnitude.
  - All other opcodes: ERROR.
- Single-cycle ops (SHL, U2_TO_ZM, illegal opcode):
  - o_result, o_status and o_done=1 are visible after E0.
  - o_busy stays 0.
  - o_done drops next cycle unless a new command is accepted.
- MUL:
  - FSM IDLE -> MUL at E0; o_busy=1.
  - Iteration edges E1..EM. Each edge: if the multiplier LSB is set, add the multiplicand to a 2M-bit accumulator; then shift the multiplicand left by 1 and the multiplier right by 1.
  - At EM: o_result and o_status written, o_done=1, o_busy=0, FSM -> IDLE.
  - A new i_start is accepted at EM+1 at the earliest.
- SHL rules:
  - If B >= M: ERROR.
  - Else OVERFLOW = 1 when any bit shifted out is 1, i.e. B>0 and |(A >> (M-B)).
  - B=0 gives o_result=A, OVERFLOW=0.
- MUL rule: OVERFLOW = |(high M bits of the 2M-bit product).
- U2_TO_ZM rules:
  - A[M-1]=0: o_result=A.
  - A[M-1]=1: o_result = {1'b1, low M-1 bits of (~A+1)}.
  - A = {1'b1, zeros} (most negative) is not representable: o_result saturates to all-ones, OVERFLOW=1.
- Status, computed on the newly written result in the same update (never on the previous one):
  - ZEROS = (new result == 0).
  - NOT_EVEN_1 = ^new result.
- On ERROR:
  - o_status = 4'b1000 exactly.
  - o_result holds its previous value.
  - o_done still pulses.
- o_status and o_result hold between commands. Only o_done marks fresh data.

Optional Feature:
Macro: SYNC_INV_MUL_EARLY_TERM_EN.
- Defined: MUL completes at the first iteration edge after which the remaining multiplier bits are all zero. At least one iteration always runs (B=0 or B=1 -> done at E1). Result is identical to the fixed-latency version.
- Undefined: MUL always takes exactly M iteration edges, regardless of operand values.

Test Plan (M=8):
- MUL A=15, B=17 -> at E8: o_result=8'hFF, o_status=4'b0000, o_done pulse; o_busy=1 during E1..E7. With the macro defined, done at E5.
- MUL A=16, B=16 -> o_result=8'h00, o_status=4'b0011 (ZEROS, OVERFLOW); an i_start pulsed mid-operation is ignored, with no second o_done.
- SHL A=8'h81, B=1 -> after E0: o_result=8'h02, o_status=4'b0101. Then SHL B=8 -> o_status=4'b1000, o_result stays 8'h02.
- U2_TO_ZM A=8'hFB -> o_result=8'h85, o_status=4'b0100. A=8'h80 -> o_result=8'hFF, o_status=4'b0001.
- iop=4'b0111 -> o_status=4'b1000, o_done pulse, o_busy=0.
- Assert i_reset=0 at E3 of MUL 200*3 -> all outputs 0 immediately. After release, MUL 3*5 -> o_result=8'h0F, o_status=4'b0000.
